// File: rtl/edge_pkg.sv
// Shared types and constants for the multi-channel edge detector:
// per-channel FSM state encoding and tick-select mode codes.
package edge_pkg;

    typedef enum logic [2:0] {
        LOW       = 3'd0,
        RISE_PEND = 3'd1,
        RISE_TICK = 3'd2,
        HIGH      = 3'd3,
        FALL_PEND = 3'd4,
        FALL_TICK = 3'd5
    } edge_state_e;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // Debounced level is high from the accepted rising edge until a falling edge is accepted
    function automatic logic state_is_high(input edge_state_e st);
        logic res;
        case (st)
            RISE_TICK: res = 1'b1;
            HIGH:      res = 1'b1;
            FALL_PEND: res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchroniser chain, debounce counter, Moore edge FSM
// and sticky event flag. All outputs come straight from flops.
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level_in,
    input  logic clear_in,
    input  logic sel_tick_in,
    output logic rise_tick,
    output logic fall_tick,
    output logic level_db,
    output logic event_flag
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    edge_state_e            state_q, state_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   db_q, db_d;
    logic                   flag_q, flag_d;
    logic                   s_s;

    assign s_s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift and sticky-flag next state (set beats clear)
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], level_in};
        if (sel_tick_in) begin
            flag_d = 1'b1;
        end else if (clear_in) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // Edge FSM next state; counter restarts on every pending-state entry and never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW: begin
                if (s_s) begin
                    state_d = RISE_PEND;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = LOW;
                end
            end
            RISE_PEND: begin
                if (!s_s) begin
                    state_d = LOW;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = RISE_TICK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RISE_TICK: state_d = HIGH;
            HIGH: begin
                if (!s_s) begin
                    state_d = FALL_PEND;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = HIGH;
                end
            end
            FALL_PEND: begin
                if (s_s) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = FALL_TICK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FALL_TICK: state_d = LOW;
            default: begin
                state_d = LOW;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so the flops mirror the Moore decode of state_q
    always_comb begin
        rise_d = (state_d == RISE_TICK);
        fall_d = (state_d == FALL_TICK);
        db_d   = state_is_high(state_d);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            cnt_q   <= CNT_ZERO;
            state_q <= LOW;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            db_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            db_q    <= db_d;
            flag_q  <= flag_d;
        end
    end

    assign rise_tick  = rise_q;
    assign fall_tick  = fall_q;
    assign level_db   = db_q;
    assign event_flag = flag_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N independent debounced edge-detector channels plus the shared
// mode mux that selects which accepted edges appear on tick.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] level,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] clear,
    output logic [CHANNELS-1:0] rise_tick,
    output logic [CHANNELS-1:0] fall_tick,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] level_db,
    output logic [CHANNELS-1:0] event_flag
);

    logic [CHANNELS-1:0] tick_s;

    // Mode select acts in the same cycle; inputs are registered ticks only
    always_comb begin
        tick_s = {CHANNELS{1'b0}};
        case (mode)
            MODE_RISE: tick_s = rise_tick;
            MODE_FALL: tick_s = fall_tick;
            MODE_BOTH: tick_s = rise_tick | fall_tick;
            MODE_OFF:  tick_s = {CHANNELS{1'b0}};
            default:   tick_s = {CHANNELS{1'b0}};
        endcase
    end

    assign tick = tick_s;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .level_in   (level[i]),
            .clear_in   (clear[i]),
            .sel_tick_in(tick_s[i]),
            .rise_tick  (rise_tick[i]),
            .fall_tick  (fall_tick[i]),
            .level_db   (level_db[i]),
            .event_flag (event_flag[i])
        );
    end

endmodule
